// File: rtl/ncl_dualrail_sink_pkg.sv
// Shared types for the dual-rail NCL word sink: per-digit state and rail-pair class codes.
package ncl_dualrail_sink_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HELD  = 2'd2,
        ST_DRAIN = 2'd3
    } digit_state_e;

    // Rail pair is packed as {rail_t, rail_f}
    localparam logic [1:0] CLS_NULL    = 2'b00;
    localparam logic [1:0] CLS_DATA0   = 2'b01;
    localparam logic [1:0] CLS_DATA1   = 2'b10;
    localparam logic [1:0] CLS_ILLEGAL = 2'b11;

    localparam int unsigned CNTW = 32;

    function automatic logic holds_bit(digit_state_e s);
        return (s == ST_FULL) || (s == ST_HELD);
    endfunction

endpackage

// File: rtl/ncl_dualrail_sink_if.sv
// Dual-rail digit stream plus assembled-word status between a producer/observer and the sink.
interface ncl_dualrail_sink_if #(
    parameter int unsigned DIGITS = 32,
    parameter int unsigned ERRW   = 16
);
    logic [DIGITS-1:0] rail_t;
    logic [DIGITS-1:0] rail_f;
    logic [DIGITS-1:0] ack;
    logic [DIGITS-1:0] word;
    logic              word_valid;
    logic [ERRW-1:0]   seq_err_count;
    logic              illegal_seen;
    logic [31:0]       word_count;

    modport master (
        output rail_t, rail_f,
        input  ack, word, word_valid, seq_err_count, illegal_seen, word_count
    );

    modport slave (
        input  rail_t, rail_f,
        output ack, word, word_valid, seq_err_count, illegal_seen, word_count
    );
endinterface

// File: rtl/ncl_dualrail_sink_digit.sv
// One dual-rail digit: two-flop rail synchronizer, capture/handshake FSM and ack decode.
module ncl_digit_sink
    import ncl_dualrail_sink_pkg::*;
(
    input  logic clk,
    input  logic init,
    input  logic rail_t,
    input  logic rail_f,
    input  logic word_release,
    output logic ack,
    output logic flag_c,
    output logic data_bit,
    output logic illegal_c
);

    logic [1:0]   sync1_q;
    logic [1:0]   sync2_q;
    digit_state_e state_q, state_d;
    logic         bit_q, bit_d;
    logic         ack_q, ack_d;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            sync1_q <= CLS_NULL;
            sync2_q <= CLS_NULL;
            state_q <= ST_EMPTY;
            bit_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            sync1_q <= {rail_t, rail_f};
            sync2_q <= sync1_q;
            state_q <= state_d;
            bit_q   <= bit_d;
            ack_q   <= ack_d;
        end
    end

    // An ILLEGAL pair matches no input arc below, so the state simply holds
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        case (state_q)
            ST_EMPTY: begin
                if (sync2_q == CLS_DATA0 || sync2_q == CLS_DATA1) begin
                    state_d = ST_FULL;
                    bit_d   = sync2_q[1];
                end
            end
            ST_FULL: begin
                if (word_release)               state_d = ST_DRAIN;
                else if (sync2_q == CLS_NULL)   state_d = ST_HELD;
            end
            ST_HELD: begin
                if (word_release)               state_d = ST_EMPTY;
            end
            ST_DRAIN: begin
                if (sync2_q == CLS_NULL)        state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
        ack_d = (state_d != ST_EMPTY);
    end

    assign ack       = ack_q;
    assign data_bit  = bit_q;
    assign flag_c    = holds_bit(state_q);
    assign illegal_c = (sync2_q == CLS_ILLEGAL);

endmodule

// File: rtl/ncl_dualrail_sink.sv
// Dual-rail NCL word sink: releases a word once every digit holds a bit, then checks +1 sequencing.
module ncl_dualrail_sink
    import ncl_dualrail_sink_pkg::*;
#(
    parameter int unsigned DIGITS = 32,
    parameter int unsigned ERRW   = 16
) (
    input  logic                clk,
    input  logic                init,
    ncl_dualrail_sink_if.slave  bus
);

    logic [DIGITS-1:0] ack_w;
    logic [DIGITS-1:0] flag_w;
    logic [DIGITS-1:0] bit_w;
    logic [DIGITS-1:0] ill_w;
    logic              release_c;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        ncl_digit_sink u_digit (
            .clk          (clk),
            .init         (init),
            .rail_t       (bus.rail_t[g]),
            .rail_f       (bus.rail_f[g]),
            .word_release (release_c),
            .ack          (ack_w[g]),
            .flag_c       (flag_w[g]),
            .data_bit     (bit_w[g]),
            .illegal_c    (ill_w[g])
        );
    end

    assign release_c = &flag_w;

    logic [DIGITS-1:0] word_q, word_d;
    logic [DIGITS-1:0] expect_q, expect_d;
    logic              word_valid_q, word_valid_d;
    logic [ERRW-1:0]   err_q, err_d;
    logic              illegal_q, illegal_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              first_q, first_d;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            word_q       <= '0;
            expect_q     <= '0;
            word_valid_q <= 1'b0;
            err_q        <= '0;
            illegal_q    <= 1'b0;
            count_q      <= '0;
            first_q      <= 1'b1;
        end else begin
            word_q       <= word_d;
            expect_q     <= expect_d;
            word_valid_q <= word_valid_d;
            err_q        <= err_d;
            illegal_q    <= illegal_d;
            count_q      <= count_d;
            first_q      <= first_d;
        end
    end

    // Expected value is reloaded on every release so a single glitch counts once
    always_comb begin
        word_d       = word_q;
        expect_d     = expect_q;
        word_valid_d = 1'b0;
        err_d        = err_q;
        count_d      = count_q;
        first_d      = first_q;
        illegal_d    = illegal_q | (|ill_w);
        if (release_c) begin
            word_d       = bit_w;
            word_valid_d = 1'b1;
            count_d      = count_q + CNTW'(1);
            expect_d     = bit_w + DIGITS'(1);
            first_d      = 1'b0;
            if (!first_q && (bit_w != expect_q) && (err_q != {ERRW{1'b1}}))
                err_d = err_q + ERRW'(1);
        end
    end

    assign bus.ack           = ack_w;
    assign bus.word          = word_q;
    assign bus.word_valid    = word_valid_q;
    assign bus.seq_err_count = err_q;
    assign bus.illegal_seen  = illegal_q;
    assign bus.word_count    = count_q;

endmodule

// File: doc/ncl_dualrail_sink.md
Name: ncl_dualrail_sink

Overview:
- Clocked receiver and checker for a dual-rail NCL digit stream, such as the sum output of the two-D pipelined 32-bit counter.
- Replaces the per-digit TH12 auto-consume gates. Each digit gets its own completion/acknowledge handshake.
- Digits are allowed to complete out of order, as two-D pipelining does.
- Assembles complete words, emits them as binary and checks that successive words increment by exactly 1.

Parameters:
- DIGITS, 32, number of dual-rail digits (word width in bits).
- ERRW, 16, width of the sequence-error counter.

Ports:
- clk  input  1  sampling clock.
- init  input  1  asynchronous active-high reset.
- rail_t  input  DIGITS  rail 1 of each digit (digit i = {rail_t[i], rail_f[i]}).
- rail_f  input  DIGITS  rail 0 of each digit.
- ack  output  DIGITS  per-digit completion. 1 means "DATA taken, send NULL"; 0 means "ready for DATA".
- word  output  DIGITS  last assembled binary word.
- word_valid  output  1  one-cycle pulse when word updates.
- seq_err_count  output  ERRW  count of non-incrementing words, saturating.
- illegal_seen  output  1  sticky: some digit showed both rails high.
- word_count  output  32  words assembled since reset, wraps.

Behaviour:
- Reset (init=1, asynchronous): every digit goes to EMPTY, ack=0, word=0, word_valid=0, counts=0, illegal_seen=0, first-word flag set. Reset mid-handshake abandons all partial digits.
- Input sync: each rail passes through a two-flop synchronizer.
  - Digit classes: DATA (exactly one rail high), NULL (both low), ILLEGAL (both high).
  - Latency: rails stable before edge n → synced at edge n+1 → state/ack change at edge n+2.
- Per-digit FSM, registered, ack is a decode of state:
  - EMPTY (ack 0): DATA → FULL, capturing bit = rail_t.
  - FULL (ack 1, flag set): NULL → HELD. Word release → DRAIN.
  - HELD (ack 1, flag set): word release → EMPTY.
  - DRAIN (ack 1, no flag): NULL → EMPTY.
  - ILLEGAL sampled in any state: no transition; illegal_seen set on the next edge.
- Word release:
  - Condition: every digit's flag is set (FULL or HELD), evaluated on current state.
  - On that edge: word ← captured bits, word_valid=1 for exactly one cycle, word_count++, FULL→DRAIN, HELD→EMPTY.
  - A digit in HELD holds ack high until release, stalling its producer in NULL. This is the backpressure mechanism.
  - If release and a NULL arrive on the same edge for a FULL digit, release wins: FULL→DRAIN, and NULL is handled on the following edge, giving DRAIN→EMPTY.
- Sequence check:
  - First release after reset seeds expected = word+1, no check.
  - Each later release compares with expected, mod 2^DIGITS. Wrap from all-ones to 0 is legal.
  - On mismatch, seq_err_count increments, saturating at all-ones.
  - expected is always reloaded to word+1, so one glitch counts once.
- A digit that sees DATA again while in DRAIN (no NULL in between) stays in DRAIN. NULL is required before the next capture.

Decomposition:
- Shared package holds:
  - Digit state enum: EMPTY, FULL, HELD, DRAIN.
  - Dual-rail class decode constants: NULL, DATA0, DATA1, ILLEGAL.
- Sub-module ncl_digit_sink, instantiated DIGITS times:
  - Contains the synchronizer, per-digit FSM, captured bit and ack.
  - Inputs: release, clk, init.
  - Outputs: flag, bit, illegal.
- Top level holds the release AND-reduce, word register, sequence checker and counters.

Test Plan:
- DIGITS=4, drive all digits DATA encoding 5, then NULL after ack → ack=4'b1111 two edges after DATA; one word_valid with word=4'h5; ack returns to 0 two edges after NULL; word_count=1.
- Skewed arrival: digit 0 DATA and NULL 10 cycles before digits 1–3 → digit 0 holds ack=1 in HELD until release; single word_valid; no seq error.
- Sequence 5, 6, 8, 9 → seq_err_count=1 after word 8; word 9 gives no further error.
- Wrap: words 4'hF then 4'h0 → seq_err_count stays 0.
- Drive digit 2 as both rails high for 3 cycles, then DATA → illegal_seen=1 sticky; digit 2 is captured only after legal DATA; word correct.
- Assert init while digits are FULL/HELD → ack=0, word_valid=0 and all counts 0 immediately. The next word after reset is seeded with no error.
